axi_write_queue: RTL and testbench

Write-request FIFO that sits directly upstream of the AXI-Lite write master, on its low-priority (FSM) port. Control FSMs push address/data pairs without stalling on the bus. The queue presents the oldest pair to the master with a level `req` and retires it on the master's single-cycle `ack`. This decouples burst-generating control logic from AXI write latency and from maestro-side priority stalls.

---
 rtl/axi_write_queue_if.sv | 8 +
 rtl/axi_write_queue.sv | 120 ++++++++++++
 tb/tb_axi_write_queue.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_queue_if.sv
// ADAM_SEQ: clock and synchronous active-low reset bundle shared by sequential blocks.
interface ADAM_SEQ;
   logic clk;
   logic rst;

   modport Master (output clk, output rst);
   modport Slave (input clk, input rst);
endinterface

// File: rtl/axi_write_queue.sv
// axi_write_queue: write-request FIFO feeding the AXI-Lite write master's FSM port.
// Optional statistics counters are enabled by defining AXI_WRITE_QUEUE_STATS_EN.
module axi_write_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   ADAM_SEQ.Slave            seq_port,
   input  logic [31:0]       push_adress_i,
   input  logic [31:0]       push_data_i,
   input  logic              push_valid_i,
   output logic              push_ready_o,
   output logic [31:0]       fsm_adress_o,
   output logic [31:0]       fsm_data_o,
   output logic              fsm_req_o,
   input  logic              fsm_ack_i,
   output logic [PTR_W:0]    count_o,
   output logic              spurious_ack_o,
   output logic [31:0]       acked_total_o,
   output logic [PTR_W:0]    high_water_o
);

   localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

   logic [63:0]      mem_q [DEPTH];
   logic [63:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             spurious_q, spurious_d;
   logic             push_acc, pop_acc;

   // Handshake qualification and pointer/count/storage next state.
   always_comb begin
      push_acc   = push_valid_i && (count_q != FullCnt);
      pop_acc    = fsm_ack_i && (count_q != '0);
      mem_d      = mem_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      spurious_d = spurious_q;
      if (push_acc) begin
         mem_d[wp_q] = {push_adress_i, push_data_i};
         wp_d        = wp_q + PTR_W'(1);
      end
      if (pop_acc) begin
         rp_d = rp_q + PTR_W'(1);
      end
      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
      // An ack with nothing queued is a master protocol error; remember it until reset.
      if (fsm_ack_i && (count_q == '0)) begin
         spurious_d = 1'b1;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge seq_port.clk) begin
      if (!seq_port.rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         spurious_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         spurious_q <= spurious_d;
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge seq_port.clk) begin
      mem_q <= mem_d;
   end

   assign push_ready_o   = (count_q != FullCnt);
   assign fsm_req_o      = (count_q != '0);
   assign fsm_adress_o   = mem_q[rp_q][63:32];
   assign fsm_data_o     = mem_q[rp_q][31:0];
   assign count_o        = count_q;
   assign spurious_ack_o = spurious_q;

`ifdef AXI_WRITE_QUEUE_STATS_EN
   logic [31:0]    acked_q, acked_d;
   logic [PTR_W:0] hw_q, hw_d;

   // Retired-write counter and occupancy high-water mark.
   always_comb begin
      acked_d = acked_q;
      hw_d    = hw_q;
      if (pop_acc) begin
         acked_d = acked_q + 32'd1;
      end
      if (count_d > hw_q) begin
         hw_d = count_d;
      end
   end

   // Statistics registers.
   always_ff @(posedge seq_port.clk) begin
      if (!seq_port.rst) begin
         acked_q <= '0;
         hw_q    <= '0;
      end else begin
         acked_q <= acked_d;
         hw_q    <= hw_d;
      end
   end

   assign acked_total_o = acked_q;
   assign high_water_o  = hw_q;
`else
   assign acked_total_o = '0;
   assign high_water_o  = '0;
`endif

endmodule

// File: tb/tb_axi_write_queue.sv
// Self-checking bench for axi_write_queue with a queue-based scoreboard.
module tb_axi_write_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   ADAM_SEQ seq ();

   logic [31:0]   push_adress_i, push_data_i;
   logic          push_valid_i, push_ready_o;
   logic [31:0]   fsm_adress_o, fsm_data_o;
   logic          fsm_req_o, fsm_ack_i;
   logic [CW-1:0] count_o, high_water_o;
   logic          spurious_ack_o;
   logic [31:0]   acked_total_o;

   axi_write_queue #(.DEPTH(DEPTH)) dut (
      .seq_port       (seq.Slave),
      .push_adress_i  (push_adress_i),
      .push_data_i    (push_data_i),
      .push_valid_i   (push_valid_i),
      .push_ready_o   (push_ready_o),
      .fsm_adress_o   (fsm_adress_o),
      .fsm_data_o     (fsm_data_o),
      .fsm_req_o      (fsm_req_o),
      .fsm_ack_i      (fsm_ack_i),
      .count_o        (count_o),
      .spurious_ack_o (spurious_ack_o),
      .acked_total_o  (acked_total_o),
      .high_water_o   (high_water_o)
   );

   initial seq.clk = 1'b0;
   always #5 seq.clk = ~seq.clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] sb[$];
   int unsigned m_acked;
   int unsigned m_hw;
   logic        m_spur;

   function automatic logic [31:0] exp_acked();
`ifdef AXI_WRITE_QUEUE_STATS_EN
      return m_acked;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [CW-1:0] exp_hw();
`ifdef AXI_WRITE_QUEUE_STATS_EN
      return CW'(m_hw);
`else
      return '0;
`endif
   endfunction

   // One clock of stimulus; updates the reference model and reports any popped entry.
   task automatic step(input logic push, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, output logic popped, output logic [63:0] exp_e,
                       output logic [63:0] obs_e);
      int pre;
      push_valid_i  = push;
      push_adress_i = a;
      push_data_i   = d;
      fsm_ack_i     = ack;
      obs_e         = {fsm_adress_o, fsm_data_o};
      popped        = 1'b0;
      exp_e         = '0;
      pre           = sb.size();
      @(posedge seq.clk);
      #1;
      if (ack && pre != 0) begin
         exp_e  = sb.pop_front();
         popped = 1'b1;
         m_acked++;
      end else if (ack) begin
         m_spur = 1'b1;
      end
      if (push && pre != DEPTH) sb.push_back({a, d});
      if (sb.size() > m_hw) m_hw = sb.size();
      push_valid_i = 1'b0;
      fsm_ack_i    = 1'b0;
   endtask

   task automatic apply_reset();
      seq.rst      = 1'b0;
      push_valid_i = 1'b0;
      fsm_ack_i    = 1'b0;
      @(posedge seq.clk);
      #1;
      seq.rst = 1'b1;
      sb.delete();
      m_acked = 0;
      m_hw    = 0;
      m_spur  = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (fsm_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", fsm_req_o); end
      n_checks++;
      if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", push_ready_o); end
      n_checks++;
      if (count_o !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
      n_checks++;
      if (spurious_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_spur got %b want 0", spurious_ack_o); end
      n_checks++;
      if (acked_total_o !== 32'd0 || high_water_o !== '0) begin
         n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", acked_total_o, high_water_o);
      end
   endtask

   task automatic test_single();
      logic p; logic [63:0] e, o;
      apply_reset();
      step(1'b1, 32'h1000, 32'hA5A5_A5A5, 1'b0, p, e, o);
      n_checks++;
      if (fsm_req_o !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", fsm_req_o); end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({fsm_adress_o, fsm_data_o} !== sb[0]) begin
            n_fail++; $display("FAIL single_head got %h want %h", {fsm_adress_o, fsm_data_o}, sb[0]);
         end
         step(1'b0, 32'h0, 32'h0, 1'b0, p, e, o);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
      n_checks++;
      if (!p || o !== e) begin n_fail++; $display("FAIL single_pop got %h want %h", o, e); end
      n_checks++;
      if (fsm_req_o !== 1'b0 || count_o !== '0) begin
         n_fail++; $display("FAIL single_empty got req=%b cnt=%0d want 0/0", fsm_req_o, count_o);
      end
   endtask

   task automatic test_fill();
      logic p; logic [63:0] e, o;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 32'(i * 4), $urandom, 1'b0, p, e, o);
         n_checks++;
         if (count_o !== CW'(sb.size())) begin
            n_fail++; $display("FAIL fill_count got %0d want %0d", count_o, sb.size());
         end
      end
      n_checks++;
      if (push_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", push_ready_o); end
      step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, p, e, o);
      n_checks++;
      if (count_o !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_9th got %0d want %0d", count_o, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
         n_checks++;
         if (!p || o !== e || o[63:32] !== 32'(i * 4)) begin
            n_fail++; $display("FAIL fill_drain got %h want %h", o, e);
         end
      end
      n_checks++;
      if (fsm_req_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", fsm_req_o); end
   endtask

   task automatic test_simul();
      logic p; logic [63:0] e, o;
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(i), $urandom, 1'b0, p, e, o);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'h3000 + 32'(i), $urandom, 1'b1, p, e, o);
         n_checks++;
         if (!p || o !== e || count_o !== 4'd3) begin
            n_fail++; $display("FAIL simul_cycle got %h cnt=%0d want %h cnt=3", o, count_o, e);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
         n_checks++;
         if (!p || o !== e) begin n_fail++; $display("FAIL simul_drain got %h want %h", o, e); end
      end
   endtask

   task automatic test_full_simul();
      logic p; logic [63:0] e, o;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h4000 + 32'(i), $urandom, 1'b0, p, e, o);
      step(1'b1, 32'hBAD0, 32'hBAD1, 1'b1, p, e, o);
      n_checks++;
      if (!p || o !== e || count_o !== 4'd7) begin
         n_fail++; $display("FAIL fullsim_cycle got %h cnt=%0d want %h cnt=7", o, count_o, e);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
         n_checks++;
         if (!p || o !== e) begin n_fail++; $display("FAIL fullsim_drain got %h want %h", o, e); end
      end
      n_checks++;
      if (fsm_req_o !== 1'b0 || count_o !== '0) begin
         n_fail++; $display("FAIL fullsim_empty got req=%b cnt=%0d want 0/0", fsm_req_o, count_o);
      end
   endtask

   task automatic test_spurious();
      logic p; logic [63:0] e, o;
      apply_reset();
      step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
      n_checks++;
      if (spurious_ack_o !== m_spur || count_o !== '0 || fsm_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL spur_set got spur=%b cnt=%0d req=%b want %b/0/0",
                  spurious_ack_o, count_o, fsm_req_o, m_spur);
      end
      step(1'b1, 32'h5000, 32'h1234_5678, 1'b0, p, e, o);
      step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
      n_checks++;
      if (!p || o !== e || count_o !== '0) begin
         n_fail++; $display("FAIL spur_roundtrip got %h cnt=%0d want %h cnt=0", o, count_o, e);
      end
      n_checks++;
      if (spurious_ack_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %b want 1", spurious_ack_o); end
   endtask

   task automatic test_stats();
      logic p; logic [63:0] e, o;
      apply_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h6000 + 32'(i), $urandom, 1'b0, p, e, o);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
         n_checks++;
         if (!p || o !== e) begin n_fail++; $display("FAIL stats_drain got %h want %h", o, e); end
      end
      n_checks++;
      if (acked_total_o !== exp_acked()) begin
         n_fail++; $display("FAIL stats_acked got %0d want %0d", acked_total_o, exp_acked());
      end
      n_checks++;
      if (high_water_o !== exp_hw()) begin
         n_fail++; $display("FAIL stats_hw got %0d want %0d", high_water_o, exp_hw());
      end
   endtask

   task automatic test_reset_mid();
      logic p; logic [63:0] e, o;
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'h7000 + 32'(i), $urandom, 1'b0, p, e, o);
      step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
      seq.rst       = 1'b0;
      push_valid_i  = 1'b1;
      fsm_ack_i     = 1'b1;
      @(posedge seq.clk);
      #1;
      seq.rst      = 1'b1;
      push_valid_i = 1'b0;
      fsm_ack_i    = 1'b0;
      sb.delete();
      m_acked = 0;
      m_hw    = 0;
      m_spur  = 1'b0;
      n_checks++;
      if (fsm_req_o !== 1'b0 || push_ready_o !== 1'b1 || count_o !== '0 || spurious_ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_ctrl got req=%b rdy=%b cnt=%0d spur=%b want 0/1/0/0",
                  fsm_req_o, push_ready_o, count_o, spurious_ack_o);
      end
      n_checks++;
      if (acked_total_o !== 32'd0 || high_water_o !== '0) begin
         n_fail++; $display("FAIL midrst_stats got %0d/%0d want 0/0", acked_total_o, high_water_o);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, p, e, o);
      n_checks++;
      if (spurious_ack_o !== 1'b1 || count_o !== '0) begin
         n_fail++; $display("FAIL midrst_spur got spur=%b cnt=%0d want 1/0", spurious_ack_o, count_o);
      end
   endtask

   initial begin
      seq.rst       = 1'b1;
      push_valid_i  = 1'b0;
      push_adress_i = '0;
      push_data_i   = '0;
      fsm_ack_i     = 1'b0;
      m_acked       = 0;
      m_hw          = 0;
      m_spur        = 1'b0;
      @(posedge seq.clk);
      #1;
      test_reset();
      test_single();
      test_fill();
      test_simul();
      test_full_simul();
      test_spurious();
      test_stats();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
